// File: rtl/burst_mem_arb_pkg.sv
// Shared types and width helpers for the burst memory arbiter.
package burst_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Beat counter width; a single-beat burst still needs a 1-bit counter.
  function automatic int beat_cnt_w(input int burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

  function automatic int grant_w(input int num_ports);
    return (num_ports <= 2) ? 1 : $clog2(num_ports);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner select: rotating search from ptr_i, or fixed
// priority (index 0 highest) when RR_MODE is 0.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int RR_MODE   = 1,
  parameter int GNT_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [GNT_W-1:0]     ptr_i,
  output logic                 valid_o,
  output logic [GNT_W-1:0]     winner_o
);

  always_comb begin
    int start;
    int idx;
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    start    = (RR_MODE != 0) ? int'(ptr_i) : 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (start + i) % NUM_PORTS;
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = GNT_W'(idx);
      end
    end
  end

endmodule

// File: rtl/burst_mem_arbiter.sv
// Arbitrates NUM_PORTS cacheline requestors onto one burst memory port,
// splitting each line transfer into BURST_LEN beats of BEAT_W bits.
module burst_mem_arbiter
  import burst_mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4,
  parameter int LINE_W    = BEAT_W * BURST_LEN,
  parameter int RR_MODE   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           req_read_i,
  input  logic [NUM_PORTS-1:0]           req_write_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]    req_addr_i,
  input  logic [NUM_PORTS*LINE_W-1:0]    req_wdata_i,
  output logic [NUM_PORTS-1:0]           req_resp_o,
  output logic [LINE_W-1:0]              req_rdata_o,
  output logic                           mem_read_o,
  output logic                           mem_write_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  output logic [BEAT_W-1:0]              mem_wdata_o,
  input  logic [BEAT_W-1:0]              mem_rdata_i,
  input  logic                           mem_resp_i,
  output logic [grant_w(NUM_PORTS)-1:0]  grant_id_o,
  output logic                           busy_o
);

  localparam int GNT_W = grant_w(NUM_PORTS);
  localparam int CNT_W = beat_cnt_w(BURST_LEN);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [GNT_W-1:0]  LAST_PORT = GNT_W'(NUM_PORTS - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       beat_q;
  logic [GNT_W-1:0]       ptr_q;
  logic [GNT_W-1:0]       grant_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [LINE_W-1:0]      wline_q;
  logic [LINE_W-1:0]      rline_q;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [NUM_PORTS-1:0]   resp_q;

  logic [ADDR_W-1:0]      port_addr  [NUM_PORTS];
  logic [LINE_W-1:0]      port_wdata [NUM_PORTS];
  logic                   arb_valid;
  logic [GNT_W-1:0]       arb_winner;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign port_addr[gi]  = req_addr_i[gi*ADDR_W +: ADDR_W];
    assign port_wdata[gi] = req_wdata_i[gi*LINE_W +: LINE_W];
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .RR_MODE   (RR_MODE),
    .GNT_W     (GNT_W)
  ) u_arb (
    .req_i    (req_read_i | req_write_i),
    .ptr_i    (ptr_q),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      wline_q     <= '0;
      rline_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      resp_q      <= '0;
    end else begin
      resp_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_q     <= arb_winner;
            addr_q      <= port_addr[arb_winner] & ADDR_MASK;
            wline_q     <= port_wdata[arb_winner];
            // Write wins when a port raises both read and write.
            mem_write_q <= req_write_i[arb_winner];
            mem_read_q  <= ~req_write_i[arb_winner];
            beat_q      <= '0;
            state_q     <= BURST;
          end
        end
        BURST: begin
          if (mem_resp_i) begin
            if (mem_read_q) begin
              rline_q[int'(beat_q)*BEAT_W +: BEAT_W] <= mem_rdata_i;
            end
            if (beat_q == LAST_BEAT) begin
              beat_q      <= '0;
              mem_read_q  <= 1'b0;
              mem_write_q <= 1'b0;
              resp_q      <= NUM_PORTS'(1) << grant_q;
              state_q     <= DONE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        DONE: begin
          ptr_q   <= (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_resp_o  = resp_q;
  assign req_rdata_o = rline_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wline_q[int'(beat_q)*BEAT_W +: BEAT_W];
  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q != IDLE);

endmodule
